// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier that retires one multiplier bit per clock, with a start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add a sign_mode input for two's-complement operands.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               sign_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    logic neg_load;

    // Magnitudes of signed operands; -2^(WIDTH-1) maps onto 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        a_mag    = (sign_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag    = (sign_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_load = sign_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
`ifdef SEQ_MULT_SIGNED_EN
        result   = neg ? (~acc_next + 1'b1) : acc_next;
`else
        result   = acc_next;
`endif
    end

    assign busy = (state == CALC);

    // product and done are loaded on the edge into FIN so the result is valid for the whole done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        neg    <= neg_load;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        product <= result;
                        done    <= 1'b1;
                        state   <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised, iterative shift-add unsigned multiplier; successor to the fixed 4x4 combinational multiplier.
- Processes one multiplier bit per clock, trading latency for area.
- Uses a start/busy/done handshake so a controller or datapath sequencer can issue operations back to back.
- Product is registered and held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, captured on accepted start.
- b  input  WIDTH  multiplier, captured on accepted start.
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  one-cycle pulse, product valid.
- product  output  2*WIDTH  registered result, held until the next completion.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, product=0, internal accumulator, operand registers and counter = 0.
- Reset mid-operation: the operation is abandoned, all state returns to the reset values next edge, and no done pulse is produced.
- FSM states:
  - IDLE: busy=0. If start=1, capture a into mcand (zero-extended to 2*WIDTH) and b into mplier, clear acc and counter, go to CALC.
  - CALC: busy=1. Each cycle:
    - if mplier[0]=1 then acc <= acc + mcand;
    - mcand <= mcand << 1; mplier <= mplier >> 1; counter++.
    - When counter reaches WIDTH-1 (last bit processed), go to FIN.
  - FIN: product <= final acc; done=1 for exactly this one cycle; busy=0; go to IDLE.
- Latency: start sampled at edge N -> CALC cycles N+1..N+WIDTH -> done high during cycle N+WIDTH+1 (WIDTH=8: done 9 cycles after start). The latency is fixed and data-independent, with no early termination.
- Throughput: the next start is accepted in the IDLE cycle after FIN, so one result every WIDTH+2 cycles.
- Width rules:
  - acc is 2*WIDTH bits and never overflows, since max (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - Additions are unsigned, with the carry out of bit 2*WIDTH-1 impossible by construction.
- start while busy or during FIN: ignored, with no effect on the running operation.
- a and b are sampled only at the accepting edge; later changes are ignored.
- start and rst high together: rst wins.
- product changes only in FIN. Between operations it holds the last result, including after an ignored start.
- Zero operands still take the full latency, and product = 0.

Optional Feature:
- Macro SEQ_MULT_SIGNED_EN.
- Defined:
  - adds input port sign_mode (1 bit, captured with start);
  - when sign_mode=1, a and b are two's complement: on accept, latch neg = a[MSB]^b[MSB] and load |a|, |b| into the operand registers;
  - in FIN, product = neg ? -acc : acc (2*WIDTH two's complement);
  - the most-negative operand magnitude 2^(WIDTH-1) is handled correctly;
  - latency is unchanged;
  - sign_mode=0 behaves identically to the unsigned build.
- Undefined: no sign_mode port; unsigned only.

Test Plan:
- WIDTH=8, rst held 3 cycles, then released -> busy=0, done=0, product=16'h0000.
- a=8'd13, b=8'd11, start pulse -> busy high 8 cycles, done pulses once 9 cycles after start, product=16'd143 held afterwards.
- a=8'hFF, b=8'hFF -> product=16'hFE01; then a=8'h00, b=8'hA5 -> product=16'h0000 after the same 9-cycle latency.
- Operation a=8'd7, b=8'd6 running; assert start with a=8'd2, b=8'd2 at CALC cycle 3 -> ignored, product=16'd42; then rst at CALC cycle 4 of a new op (a=8'd9, b=8'd9) -> no done, product=0.
- Back-to-back: start held high continuously with a=8'd3, b=8'd5 -> done every 10 cycles, product=16'd15 each time; WIDTH=4 instance with a=4'hF, b=4'hF -> product=8'hE1, done 5 cycles after start.
- SEQ_MULT_SIGNED_EN, sign_mode=1, WIDTH=8:
  - a=-8'sd128, b=-8'sd1 -> product=16'h0080;
  - a=8'sd5, b=-8'sd3 -> product=16'hFFF1;
  - sign_mode=0 with a=8'h80, b=8'hFF -> product=16'h7F80.
